truth_table_scanner: RTL

//   Sequencer that exercises one N_IN-input combinational function unit, such as a SoP or PoS minterm block.
//   It drives each input vector in order 0..2^N_IN-1, waits SETTLE cycles, then samples the unit's output.
//   It assembles the sampled bits into a minterm mask and compares that mask to a latched expected mask.

---
 rtl/scan_pkg.sv | 26 ++
 rtl/settle_timer.sv | 26 ++
 rtl/truth_table_scanner.sv | 102 ++++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// scan_pkg: shared state encoding, defaults and guide mask for the truth-table scanner.
package scan_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = S_IDLE,
        WAIT   = S_WAIT,
        SAMPLE = S_SAMPLE,
        DONE   = S_DONE
    } state_t;

    localparam int DEF_N_IN   = 4;
    localparam int DEF_SETTLE = 1;

    // Minterms 0,2,6,7,9,10,12 of a 4-input function, bit i = f(i).
    localparam logic [15:0] MASK_M0_2_6_7_9_10_12 = 16'h16C5;

    function automatic logic [15:0] guide_mask();
        return MASK_M0_2_6_7_9_10_12;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// settle_timer: loadable down-counter with a zero flag, paces the settle delay per vector.
module settle_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst_i)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= load_val_i;
        else if (dec_i)
            cnt_q <= cnt_q - 1'b1;
    end

    assign zero_o = cnt_q == '0;

endmodule

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: steps a combinational unit through all input vectors,
// builds its minterm mask and compares it to a latched expected mask.
module truth_table_scanner
    import scan_pkg::*;
#(
    parameter int N_IN   = DEF_N_IN,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [(1<<N_IN)-1:0] expected,
    input  logic                 f_in,
    output logic [N_IN-1:0]      vec_out,
    output logic                 busy,
    output logic                 done,
    output logic [(1<<N_IN)-1:0] table_out,
    output logic                 mismatch,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      first_err
);

    localparam int M  = 1 << N_IN;
    localparam int TW = $clog2(SETTLE + 1);

    state_t          state_q;
    logic [M-1:0]    exp_q, table_q;
    logic [N_IN-1:0] idx_q, ferr_q;
    logic [N_IN:0]   ecnt_q;
    logic            busy_q, done_q, mis_q;
    logic            tmr_zero, bad, last;

    assign bad  = f_in != exp_q[idx_q];
    assign last = &idx_q;

    // Timer is loaded with SETTLE-1 so that zero is seen on the SETTLE-th WAIT cycle.
    settle_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst_i      (reset),
        .load_i     (state_q == IDLE || state_q == SAMPLE),
        .load_val_i (TW'(SETTLE - 1)),
        .dec_i      (state_q == WAIT && !tmr_zero),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            exp_q   <= '0;
            table_q <= '0;
            idx_q   <= '0;
            ferr_q  <= '0;
            ecnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    exp_q   <= expected;
                    table_q <= '0;
                    idx_q   <= '0;
                    ferr_q  <= '0;
                    ecnt_q  <= '0;
                    mis_q   <= 1'b0;
                    busy_q  <= 1'b1;
                    state_q <= WAIT;
                end
                WAIT: if (tmr_zero) state_q <= SAMPLE;
                SAMPLE: begin
                    table_q[idx_q] <= f_in;
                    if (bad) begin
                        ecnt_q <= ecnt_q + 1'b1;
                        if (!mis_q) begin
                            ferr_q <= idx_q;
                            mis_q  <= 1'b1;
                        end
                    end
                    if (last) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= WAIT;
                    end
                end
                DONE: state_q <= IDLE;
            endcase
        end
    end

    assign vec_out   = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign table_out = table_q;
    assign mismatch  = mis_q;
    assign err_count = ecnt_q;
    assign first_err = ferr_q;

endmodule
